// File: rtl/multiplier_seq_pkg.sv
// Shared constants and state encoding for the sequential multiplier.
// The hazard unit imports the same state names to decide when MFHI/MFLO must stall.
//   MUL_WIDTH  : default operand width (product is twice this)
//   MUL_CNT_W  : default iteration-counter width (2**MUL_CNT_W > MUL_WIDTH)
//   mul_state_t: IDLE (accepting), RUN (one shift-add per cycle), FIX (sign restore)
package multiplier_seq_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 6;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_FIX  = 2'd2
  } mul_state_t;

endpackage

// File: rtl/multiplier_seq_if.sv
// Request/response bundle between the EX stage and the sequential multiplier.
//   start     : one-cycle request, sampled by the multiplier only while it is idle
//   is_signed : 1 = MULT, 0 = MULTU (sampled with start)
//   dataA     : multiplicand (sampled with start)
//   dataB     : multiplier   (sampled with start)
//   busy      : high from the accept edge through the FIX cycle
//   done      : one-cycle pulse, dataOut valid in that cycle
//   dataOut   : {HI, LO}, held until the next completion
// Handshake: a request is taken on a rising edge where start=1 and busy=0;
// start with busy=1 is dropped (no queuing). Each accepted request produces
// exactly one done pulse, unless reset aborts it.
interface multiplier_seq_if
  import multiplier_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) ();

  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   dataA;
  logic [WIDTH-1:0]   dataB;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] dataOut;

  modport master (
    output start, is_signed, dataA, dataB,
    input  busy, done, dataOut
  );

  modport slave (
    input  start, is_signed, dataA, dataB,
    output busy, done, dataOut
  );

endinterface

// File: rtl/multiplier_seq.sv
// Iterative shift-add multiplier (MULT/MULTU) producing {HI, LO}.
// Operands are reduced to magnitudes at accept time, multiplied unsigned over
// WIDTH cycles, and the sign is restored in a final FIX cycle. Latency is fixed
// at WIDTH+2 edges from the accept edge to the end of the done cycle.
// Ports:
//   clk     : rising-edge clock
//   reset   : synchronous, active-high; aborts any operation in flight
//   bus     : multiplier_seq_if.slave (start/is_signed/dataA/dataB in,
//             busy/done/dataOut out)
//   o_state : current FSM state, for observation only
module multiplier_seq
  import multiplier_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  multiplier_seq_if.slave  bus,
  output mul_state_t       o_state
);

  // Two's-complement magnitude. 0x80..0 maps to itself, which is the correct
  // unsigned value 2**(WIDTH-1), so no extra bit is needed.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ((~v) + WIDTH'(1)) : v;
  endfunction

  mul_state_t           r_state;
  mul_state_t           w_state_next;
  logic [WIDTH:0]       r_acc;      // upper half of P plus carry bit
  logic [WIDTH-1:0]     r_mplier;   // lower half of P, consumed LSB first
  logic [WIDTH-1:0]     r_mcand;
  logic                 r_neg;
  logic [CNT_W-1:0]     r_count;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_data_out;

  logic [WIDTH:0]       w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_prod_fix;

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MUL_IDLE: if (bus.start) w_state_next = MUL_RUN;
      MUL_RUN:  if (r_count == CNT_W'(WIDTH - 1)) w_state_next = MUL_FIX;
      MUL_FIX:  w_state_next = MUL_IDLE;
      default:  w_state_next = MUL_IDLE;
    endcase
  end

  // Datapath: the add is WIDTH+1 bits wide so the carry survives into the
  // shift. r_acc[WIDTH] is always 0 after a shift, so the sum cannot overflow.
  always_comb begin
    w_addend   = r_mplier[0] ? {1'b0, r_mcand} : '0;
    w_sum      = r_acc + w_addend;
    w_prod     = {r_acc[WIDTH-1:0], r_mplier};
    // Negating zero yields zero, so a zero product never picks up a sign.
    w_prod_fix = r_neg ? ((~w_prod) + (2*WIDTH)'(1)) : w_prod;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= MUL_IDLE;
      r_acc      <= '0;
      r_mplier   <= '0;
      r_mcand    <= '0;
      r_neg      <= 1'b0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      case (r_state)
        MUL_IDLE: begin
          if (bus.start) begin
            r_mcand  <= bus.is_signed ? abs_val(bus.dataA) : bus.dataA;
            r_mplier <= bus.is_signed ? abs_val(bus.dataB) : bus.dataB;
            r_neg    <= bus.is_signed & (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        MUL_RUN: begin
          r_acc    <= {1'b0, w_sum[WIDTH:1]};
          r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
          r_count  <= r_count + CNT_W'(1);
        end
        MUL_FIX: begin
          r_data_out <= w_prod_fix;
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (r_state != MUL_IDLE);
  assign bus.done    = r_done;
  assign bus.dataOut = r_data_out;
  assign o_state     = r_state;

endmodule

// File: tb/tb_multiplier_seq.sv
module tb_multiplier_seq;
  import multiplier_seq_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic           s;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  mul_state_t state;
  int         checks = 0;
  int         errors = 0;

  multiplier_seq_if #(.WIDTH(W)) bus ();

  multiplier_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .o_state (state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks. Inputs change 1 time unit after a rising edge, outputs are
  // sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.dataA     = a;
    bus.dataB     = b;
    tick();
    bus.start     = 1'b0;
  endtask

  // Counts cycles from the current one (numbered 1) until done is seen.
  // cyc = -1 if done never comes within the budget.
  task automatic wait_done(output int cyc, output logic busy_ok);
    busy_ok = 1'b1;
    cyc     = -1;
    for (int i = 1; i <= 40; i++) begin
      if (bus.done === 1'b1) begin
        cyc = i;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      tick();
    end
  endtask

  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W-1:0] res, output int cyc, output logic busy_ok);
    launch(s, a, b);
    wait_done(cyc, busy_ok);
    res = bus.dataOut;
  endtask

  // Scenarios
  task automatic test_reset();
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dataA     = '0;
    bus.dataB     = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++;
    if (bus.dataOut !== 64'h0) begin errors++; $display("FAIL reset_dataout: got %h expected 0", bus.dataOut); end
    checks++;
    if (state !== MUL_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, MUL_IDLE); end
  endtask

  task automatic test_multu_basic();
    logic [2*W-1:0] res;
    int             cyc;
    logic           bok;
    run_op(1'b0, 32'd7, 32'd6, res, cyc, bok);
    checks++;
    if (res !== 64'h00000000_0000002A) begin errors++; $display("FAIL multu_7x6: got %h expected 000000000000002a", res); end
    checks++;
    if (cyc !== 34) begin errors++; $display("FAIL latency_7x6: got %0d expected 34", cyc); end
    checks++;
    if (bok !== 1'b1) begin errors++; $display("FAIL busy_window: got %b expected 1", bok); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b expected 0", bus.busy); end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", bus.done); end
    checks++;
    if (bus.dataOut !== 64'h2A) begin errors++; $display("FAIL dataout_hold: got %h expected 2a", bus.dataOut); end
  endtask

  task automatic test_vectors();
    vec_t vecs[8] = '{
      '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001},
      '{1'b0, 32'hFFFFFFFD, 32'h00000005, 64'h00000004_FFFFFFF1},
      '{1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1},
      '{1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 64'h00000000_00000010},
      '{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000},
      '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000},
      '{1'b1, 32'h00000000, 32'hFFFFFFFB, 64'h00000000_00000000},
      '{1'b0, 32'h00000000, 32'h00000000, 64'h00000000_00000000}
    };
    logic [2*W-1:0] res;
    int             cyc;
    logic           bok;
    for (int i = 0; i < 8; i++) begin
      tick();
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, res, cyc, bok);
      checks++;
      if (res !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec[%0d] %h*%h s=%b: got %h expected %h", i, vecs[i].a, vecs[i].b, vecs[i].s, res, vecs[i].exp);
      end
      checks++;
      if (cyc !== 34) begin errors++; $display("FAIL vec[%0d]_latency: got %0d expected 34", i, cyc); end
    end
  endtask

  task automatic test_start_while_busy();
    logic [2*W-1:0] res;
    int             cyc;
    logic           bok;
    tick();
    launch(1'b0, 32'd2, 32'd3);     // now in cycle 1
    repeat (4) tick();              // cycle 5
    launch(1'b1, 32'd9, 32'd9);     // ignored request; now in cycle 6
    wait_done(cyc, bok);
    res = bus.dataOut;
    checks++;
    if (res !== 64'd6) begin errors++; $display("FAIL ignore_start_result: got %h expected 6", res); end
    checks++;
    if (cyc !== 29) begin errors++; $display("FAIL ignore_start_latency: got %0d expected 29", cyc); end
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    tick();
    launch(1'b0, 32'd5, 32'd5);     // cycle 1
    repeat (9) tick();              // cycle 10
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.dataOut !== 64'h0) begin errors++; $display("FAIL abort_dataout: got %h expected 0", bus.dataOut); end
    checks++;
    if (state !== MUL_IDLE) begin errors++; $display("FAIL abort_state: got %0d expected %0d", state, MUL_IDLE); end
    for (int i = 0; i < 40; i++) begin
      if (bus.done !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d done cycles expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] res;
    int             cyc;
    logic           bok;
    run_op(1'b0, 32'd3, 32'd4, res, cyc, bok);
    checks++;
    if (res !== 64'd12) begin errors++; $display("FAIL b2b_first: got %h expected c", res); end
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", bus.done); end
    launch(1'b0, 32'h00010000, 32'h00010000);   // start in the done cycle
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", bus.busy); end
    checks++;
    if (bus.dataOut !== 64'd12) begin errors++; $display("FAIL b2b_hold_old: got %h expected c", bus.dataOut); end
    wait_done(cyc, bok);
    res = bus.dataOut;
    checks++;
    if (res !== 64'h00000001_00000000) begin errors++; $display("FAIL b2b_second: got %h expected 0000000100000000", res); end
    checks++;
    if (cyc !== 34) begin errors++; $display("FAIL b2b_latency: got %0d expected 34", cyc); end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_multu_basic();
    test_vectors();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
